// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: shared types, limits and round-robin search for gray_conv_arbiter
package gray_arb_pkg;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 16;
    localparam int WIDTH_MIN = 2;
    localparam int IDX_W     = 4;

    typedef enum logic {IDLE, FULL} state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of valid searching last+1, last+2, ... modulo n
    function automatic pick_t rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                      input logic [IDX_W-1:0] last,
                                      input int n);
        pick_t r;
        int j;
        r = '0;
        for (int k = 1; k <= N_REQ_MAX; k++) begin
            j = (int'(last) + k) % n;
            if (k <= n && !r.found && valid[j[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_xcode_core.sv
// gray_xcode_core: combinational binary->Gray encoder, or Gray->binary decoder when decode=1
module gray_xcode_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic             decode,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;

    // Encode is a single shifted XOR; decode is a prefix XOR from the MSB down
    always_comb begin
        b2g = din ^ (din >> 1);
        g2b[WIDTH-1] = din[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) g2b[k] = g2b[k+1] ^ din[k];
        dout = decode ? g2b : b2g;
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared Gray converter; GRAY_ARB_DECODE_EN adds per-port Gray->binary mode
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef GRAY_ARB_DECODE_EN
    input  logic [N_REQ-1:0]       req_decode,
`endif
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    input  logic                   out_ready
);

    state_t           state;
    logic [ID_W-1:0]  last_grant;
    pick_t            pick;
    logic             can_accept;
    logic             grant;
    logic [ID_W-1:0]  win;
    logic [WIDTH-1:0] win_data;
    logic             win_dec;
    logic [WIDTH-1:0] xcode;

    // Grant: one-hot on the round-robin winner whenever the result register can take a word
    always_comb begin
        can_accept = (state == IDLE) | out_ready;
        pick       = rr_pick(N_REQ_MAX'(req_valid), IDX_W'(last_grant), N_REQ);
        win        = ID_W'(pick.idx);
        grant      = rst_n & can_accept & pick.found;
        req_ready  = grant ? N_REQ'(1) << win : '0;
        win_data   = req_data[win*WIDTH +: WIDTH];
`ifdef GRAY_ARB_DECODE_EN
        win_dec    = req_decode[win];
`else
        win_dec    = 1'b0;
`endif
    end

    gray_xcode_core #(.WIDTH(WIDTH)) u_xcode (
        .din    (win_data),
        .decode (win_dec),
        .dout   (xcode)
    );

    // FSM and result register: load on handshake, empty on drain, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (grant) begin
            state      <= FULL;
            out_valid  <= 1'b1;
            out_data   <= xcode;
            out_id     <= win;
            last_grant <= win;
        end else if (out_ready) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
        end
    end

endmodule
